// File: rtl/change_dispenser.sv
// Coin change dispenser: greedy payout of a requested amount from four stocked
// denominations, one hopper handshake per coin, with ack timeout and refill.
module change_dispenser #(
  parameter int INIT_STOCK  = 5,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [9:0] req_amount,
  output logic       req_ready,
  output logic       coin_valid,
  output logic [1:0] coin_denom,
  input  logic       coin_ack,
  input  logic       refill,
  input  logic [1:0] refill_denom,
  input  logic [3:0] refill_count,
  output logic       done,
  output logic       error,
  output logic [9:0] shortfall,
  output logic       busy
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, DONE, FAULT} state_e;

  state_e        state_q, state_d;
  logic [9:0]    remaining_q, remaining_d;
  logic [9:0]    shortfall_q, shortfall_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    denom_q, denom_d;
  logic [7:0]    stock_q [4];
  logic [7:0]    stock_d [4];

  logic          sel_found;
  logic [1:0]    sel_denom;
  logic          ack_take;

  function automatic logic [9:0] coin_value(input logic [1:0] d);
    case (d)
      2'd0:    return 10'd1;
      2'd1:    return 10'd5;
      2'd2:    return 10'd10;
      default: return 10'd20;
    endcase
  endfunction

  // Refill and a coin decrement may land together; saturate the combined result.
  function automatic logic [7:0] sat_stock(input logic [7:0] cur, input logic [3:0] add,
                                           input logic dec);
    logic [8:0] sum;
    sum = {1'b0, cur} + {5'd0, add} - {8'd0, dec};
    return (sum > 9'd255) ? 8'd255 : sum[7:0];
  endfunction

  // Ascending scan so the last qualifying denomination (the largest) wins.
  always_comb begin
    sel_found = 1'b0;
    sel_denom = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (coin_value(2'(i)) <= remaining_q && stock_q[i] != 8'd0) begin
        sel_found = 1'b1;
        sel_denom = 2'(i);
      end
    end
  end

  assign ack_take = (state_q == ISSUE) && coin_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= 10'd0;
      shortfall_q <= 10'd0;
      timer_q     <= '0;
      denom_q     <= 2'd0;
      for (int i = 0; i < 4; i++) stock_q[i] <= 8'(INIT_STOCK);
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      shortfall_q <= shortfall_d;
      timer_q     <= timer_d;
      denom_q     <= denom_d;
      for (int i = 0; i < 4; i++) stock_q[i] <= stock_d[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    shortfall_d = shortfall_q;
    timer_d     = timer_q;
    denom_d     = denom_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          remaining_d = req_amount;
          shortfall_d = 10'd0;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        timer_d = '0;
        if (remaining_q == 10'd0) begin
          state_d = DONE;
        end else if (sel_found) begin
          denom_d = sel_denom;
          state_d = ISSUE;
        end else begin
          shortfall_d = remaining_q;
          state_d     = FAULT;
        end
      end
      ISSUE: begin
        if (coin_ack) begin
          remaining_d = remaining_q - coin_value(denom_q);
          state_d     = SELECT;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          shortfall_d = remaining_q;
          state_d     = FAULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    for (int i = 0; i < 4; i++) begin
      stock_d[i] = sat_stock(stock_q[i],
                             (refill && refill_denom == 2'(i)) ? refill_count : 4'd0,
                             ack_take && denom_q == 2'(i));
    end
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    coin_valid = (state_q == ISSUE);
    done       = (state_q == DONE);
    error      = (state_q == FAULT);
    busy       = (state_q != IDLE);
  end

  assign coin_denom = denom_q;
  assign shortfall  = shortfall_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: greedy-payout reference model feeding an event
// scoreboard, with directed corner cases and randomized requests/refills.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [9:0] req_amount;
  logic       req_ready;
  logic       coin_valid;
  logic [1:0] coin_denom;
  logic       coin_ack;
  logic       refill;
  logic [1:0] refill_denom;
  logic [3:0] refill_count;
  logic       done;
  logic       error;
  logic [9:0] shortfall;
  logic       busy;

  always #5 clk = ~clk;

  change_dispenser #(.INIT_STOCK(5), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
    .coin_valid(coin_valid), .coin_denom(coin_denom), .coin_ack(coin_ack),
    .refill(refill), .refill_denom(refill_denom), .refill_count(refill_count),
    .done(done), .error(error), .shortfall(shortfall), .busy(busy)
  );

  typedef struct {int kind; int denom; int sf;} exp_t;  // kind 0=coin 1=done 2=error

  int   tests = 0;
  int   fails = 0;
  int   m_stock [4];
  int   vals [4] = '{1, 5, 10, 20};
  int   ack_mode = 0;  // 0: random delay + stray acks, 1: immediate, 2: never
  exp_t exp_q[$];

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int pick(input int rem);
    int d = -1;
    for (int i = 0; i < 4; i++) if (vals[i] <= rem && m_stock[i] > 0) d = i;
    return d;
  endfunction

  function automatic void push(input int k, input int d, input int s);
    exp_t e;
    e.kind = k; e.denom = d; e.sf = s;
    exp_q.push_back(e);
  endfunction

  // Returns 1 when a coin offer is expected two cycles after acceptance.
  function automatic int model_request(input int amount, input int mode);
    int rem = amount;
    int d;
    int first = (amount > 0 && pick(amount) >= 0) ? 1 : 0;
    if (mode == 2) begin
      if (amount == 0) push(1, 0, 0);
      else push(2, 0, amount);
      return first;
    end
    forever begin
      if (rem == 0) begin push(1, 0, 0); break; end
      d = pick(rem);
      if (d < 0) begin push(2, 0, rem); break; end
      push(0, d, 0);
      rem -= vals[d];
      m_stock[d]--;
    end
    return first;
  endfunction

  function automatic void pop_check(input int k, input int d, input int s);
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL unexpected_event: got kind %0d, expected none (t=%0t)", k, $time);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", k, e.kind);
    if (k == 0 && e.kind == 0) check("coin_denom", d, e.denom);
    if (k == 2 && e.kind == 2) check("error_shortfall", s, e.sf);
  endfunction

  // Hopper model.
  initial begin
    int wcnt, dly;
    coin_ack = 1'b0; wcnt = 0; dly = 0;
    forever begin
      @(posedge clk); #1;
      if (coin_valid && ack_mode != 2) begin
        coin_ack = (wcnt >= dly);
        wcnt++;
      end else begin
        coin_ack = (ack_mode == 0 && !coin_valid) ? 1'($urandom_range(0, 1)) : 1'b0;
        wcnt = 0;
        dly = (ack_mode == 0) ? $urandom_range(0, 3) : 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit prev_cv, acked;
    int low_run;
    logic [1:0] prev_d;
    prev_cv = 0; acked = 0; low_run = 0; prev_d = 2'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_cv = 0; acked = 0; low_run = 0;
      end else begin
        if (coin_valid && !prev_cv && acked) check("coin_gap", low_run, 1);
        if (coin_valid && prev_cv) check("denom_stable", coin_denom, prev_d);
        if (coin_valid && coin_ack) begin pop_check(0, coin_denom, 0); acked = 1; end
        if (done || error) begin check("done_error_excl", int'(done && error), 0); acked = 0; end
        if (done) pop_check(1, 0, 0);
        if (error) pop_check(2, 0, shortfall);
        low_run = coin_valid ? 0 : low_run + 1;
        prev_cv = coin_valid; prev_d = coin_denom;
      end
    end
  end

  task automatic hard_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; refill = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) m_stock[i] = 5;
  endtask

  // Leaves the caller at the falling edge of the first cycle after SELECT.
  task automatic send_start(input int amount, input int mode);
    int first;
    ack_mode = mode;
    first = model_request(amount, mode);
    @(negedge clk);
    check("req_ready_before", req_ready, 1);
    req_valid = 1'b1; req_amount = 10'(amount);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("select_coin_valid", coin_valid, 0);
    check("select_busy", busy, 1);
    @(negedge clk);
    check("first_coin_latency", coin_valid, first);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 600) begin @(negedge clk); n++; end
    if (n >= 600) begin
      tests++; fails++;
      $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", n);
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic do_refill(input int d, input int c);
    @(negedge clk);
    refill = 1'b1; refill_denom = 2'(d); refill_count = 4'(c);
    @(posedge clk);
    m_stock[d] = (m_stock[d] + c > 255) ? 255 : m_stock[d] + c;
    @(negedge clk);
    refill = 1'b0;
  endtask

  task automatic check_stock(input string name);
    for (int i = 0; i < 4; i++) check(name, int'(dut.stock_q[i]), m_stock[i]);
  endtask

  initial begin
    int cnt, amt, md;
    reset = 1'b1; req_valid = 1'b0; req_amount = 10'd0;
    refill = 1'b0; refill_denom = 2'd0; refill_count = 4'd0;
    hard_reset();

    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_coin_valid", coin_valid, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_shortfall", shortfall, 0);
    check("rst_coin_denom", coin_denom, 0);

    // 38 -> 20,10,5,1,1,1
    send_start(38, 1);
    wait_idle();
    check("r38_stock1", int'(dut.stock_q[0]), 2);
    check("r38_stock5", int'(dut.stock_q[1]), 4);
    check("r38_stock10", int'(dut.stock_q[2]), 4);
    check("r38_stock20", int'(dut.stock_q[3]), 4);

    // zero request
    send_start(0, 1);
    check("zero_done_latency", done, 1);
    wait_idle();
    check("zero_shortfall", shortfall, 0);

    // exhaust all stock
    hard_reset();
    send_start(200, 1);
    wait_idle();
    check("r200_shortfall", shortfall, 20);
    for (int i = 0; i < 4; i++) check("r200_stock_empty", int'(dut.stock_q[i]), 0);

    // ack timeout
    hard_reset();
    send_start(5, 2);
    check("timeout_denom", coin_denom, 1);
    cnt = 1;
    while (cnt < 100) begin
      @(negedge clk);
      if (!coin_valid) break;
      cnt++;
    end
    check("timeout_valid_cycles", cnt, 15);
    wait_idle();
    check("timeout_shortfall", shortfall, 5);
    check("timeout_stock5", int'(dut.stock_q[1]), 5);

    // refill coinciding with a 20-unit ack, then saturation
    hard_reset();
    send_start(20, 1);
    refill = 1'b1; refill_denom = 2'd3; refill_count = 4'd15;
    @(posedge clk);
    m_stock[3] = m_stock[3] + 15;
    @(negedge clk);
    refill = 1'b0;
    wait_idle();
    check("refill_ack_stock20", int'(dut.stock_q[3]), 19);
    for (int i = 0; i < 17; i++) do_refill(3, 15);
    check("refill_saturate", int'(dut.stock_q[3]), 255);
    check_stock("refill_model_stock");

    // reset while a coin is offered
    hard_reset();
    send_start(38, 2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_issue_coin_valid", coin_valid, 0);
    check("rst_issue_done", done, 0);
    check("rst_issue_error", error, 0);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) m_stock[i] = 5;
    @(negedge clk);
    check("rst_issue_req_ready", req_ready, 1);
    repeat (3) @(negedge clk);
    check_stock("rst_issue_stock");

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) do_refill($urandom_range(0, 3), $urandom_range(0, 15));
      amt = (it % 7 == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 120);
      md  = ($urandom_range(0, 9) == 0) ? 2 : $urandom_range(0, 1);
      send_start(amt, md);
      wait_idle();
      check_stock("rand_stock");
    end

    ack_mode = 1;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before limit");
    $fatal(1, "watchdog");
  end

endmodule
